// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encodings, default slave address and LED register indices.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTED,
        S_PTR,
        S_HI,
        S_LO,
        S_IGNORE
    } state_t;

    localparam logic [6:0] DEFAULT_I2C_ADDRESS = 7'h21;

    localparam int LED_RED   = 0;
    localparam int LED_GREEN = 1;
    localparam int LED_BLUE  = 2;
    localparam int LED_WHITE = 3;

endpackage

// File: rtl/i2c_reg_bank_shadow.sv
// i2c_reg_bank_shadow: staged word array and dirty mask awaiting commit at stop.
module i2c_reg_bank_shadow #(
    parameter int          NUM_REGS    = 4,
    parameter int          PTR_WIDTH   = 2,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [PTR_WIDTH-1:0]     idx_i,
    input  logic [15:0]              data_i,
    input  logic                     commit_i,
    input  logic                     clear_i,
    output logic [16*NUM_REGS-1:0]   words_o,
    output logic [NUM_REGS-1:0]      dirty_o
);

    logic [15:0]         shadow_q [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) shadow_q[r] <= RESET_VALUE;
            dirty_q <= '0;
        end else begin
            if (we_i) begin
                shadow_q[idx_i] <= data_i;
                dirty_q[idx_i]  <= 1'b1;
            end
            if (commit_i || clear_i) dirty_q <= '0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_words
        assign words_o[16*g +: 16] = shadow_q[g];
    end

    assign dirty_o = dirty_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C byte-stream decoder writing 16-bit PWM duty registers,
// staged per transaction and committed atomically on stop.
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDRESS = DEFAULT_I2C_ADDRESS,
    parameter int          NUM_REGS    = 4,
    parameter int          PTR_WIDTH   = 2,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [7:0]             write_data,
    input  logic                   wr,
    output logic [16*NUM_REGS-1:0] regs_out,
    output logic                   update,
    output logic                   addressed
);

    state_t                 state_q;
    logic [PTR_WIDTH-1:0]   ptr_q;
    logic [7:0]             hi_q;
    logic [16*NUM_REGS-1:0] regs_q;
    logic                   update_q;
    logic                   addressed_q;
    logic                   sh_we;
    logic                   sh_commit;
    logic                   sh_clear;
    logic [16*NUM_REGS-1:0] staged;
    logic [NUM_REGS-1:0]    dirty;

    // start outranks stop, which outranks wr
    always_comb begin
        sh_we     = wr && !start && !stop && state_q == S_LO;
        sh_commit = stop && !start && state_q inside {S_PTR, S_HI, S_LO, S_IGNORE};
        sh_clear  = (start && state_q == S_IDLE) ||
                    (wr && !start && !stop && state_q == S_STARTED && write_data[7:1] != I2C_ADDRESS);
    end

    i2c_reg_bank_shadow #(
        .NUM_REGS    (NUM_REGS),
        .PTR_WIDTH   (PTR_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (sh_we),
        .idx_i    (ptr_q),
        .data_i   ({hi_q, write_data}),
        .commit_i (sh_commit),
        .clear_i  (sh_clear),
        .words_o  (staged),
        .dirty_o  (dirty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            hi_q        <= '0;
            regs_q      <= {NUM_REGS{RESET_VALUE}};
            update_q    <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (sh_commit && dirty[r]) regs_q[16*r +: 16] <= staged[16*r +: 16];
            update_q <= sh_commit && |dirty;
            if (start) begin
                state_q     <= S_STARTED;
                addressed_q <= 1'b0;
            end else if (stop) begin
                state_q     <= S_IDLE;
                addressed_q <= 1'b0;
            end else if (wr) begin
                case (state_q)
                    S_STARTED: begin
                        state_q     <= write_data[7:1] == I2C_ADDRESS ? S_PTR : S_IDLE;
                        addressed_q <= write_data[7:1] == I2C_ADDRESS;
                    end
                    S_PTR: begin
                        state_q <= write_data < 8'(NUM_REGS) ? S_HI : S_IGNORE;
                        ptr_q   <= write_data[PTR_WIDTH-1:0];
                    end
                    S_HI: begin
                        state_q <= S_LO;
                        hi_q    <= write_data;
                    end
                    S_LO: begin
                        state_q <= S_HI;
                        ptr_q   <= ptr_q == PTR_WIDTH'(NUM_REGS - 1) ? '0 : ptr_q + PTR_WIDTH'(1);
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign regs_out  = regs_q;
    assign update    = update_q;
    assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: table vectors, hand-built corner sequences and randomized
// transactions checked against a transaction-level model of the register bank.
module tb_i2c_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  write_data = 8'h00;
    logic [63:0] regs_out;
    logic        update;
    logic        addressed;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] cur = 64'h0;

    always #5 clk = ~clk;

    i2c_reg_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .write_data (write_data),
        .wr         (wr),
        .regs_out   (regs_out),
        .update     (update),
        .addressed  (addressed)
    );

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic [63:0] regs;
        logic        upd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 write_data = b; wr = 1'b1;
        @(posedge clk); #1 wr = 1'b0;
    endtask

    task automatic finish_txn(input string tag, input logic [63:0] exp_regs, input logic exp_upd);
        @(posedge clk); #1 stop = 1'b1;
        chk({tag, " regs before stop edge"}, regs_out, cur);
        @(posedge clk); #1 stop = 1'b0;
        chk({tag, " regs after stop"}, regs_out, exp_regs);
        chk({tag, " update after stop"}, 64'(update), 64'(exp_upd));
        @(posedge clk); #1;
        chk({tag, " update next cycle"}, 64'(update), 64'h0);
        chk({tag, " addressed after stop"}, 64'(addressed), 64'h0);
        cur = exp_regs;
    endtask

    initial begin
        vec_t        tbl [6];
        logic [15:0] pend_val [$];
        int          pend_idx [$];
        logic [63:0] exp;
        logic [7:0]  a, p, hi;
        logic        match, last_match;
        int          nb;

        tbl[0] = '{48'h42_01_12_34_00_00, 4, 64'h0000_0000_1234_0000, 1'b1};
        tbl[1] = '{48'h42_03_AA_AA_BB_BB, 6, 64'hAAAA_0000_1234_BBBB, 1'b1};
        tbl[2] = '{48'h44_01_02_03_04_00, 5, 64'hAAAA_0000_1234_BBBB, 1'b0};
        tbl[3] = '{48'h42_07_11_22_00_00, 4, 64'hAAAA_0000_1234_BBBB, 1'b0};
        tbl[4] = '{48'h42_00_55_55_66_00, 5, 64'hAAAA_0000_1234_5555, 1'b1};
        tbl[5] = '{48'h43_02_CD_EF_00_00, 4, 64'hAAAA_CDEF_1234_5555, 1'b1};

        #2;
        chk("reset regs", regs_out, 64'h0);
        chk("reset update", 64'(update), 64'h0);
        chk("reset addressed", 64'(addressed), 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle regs", regs_out, 64'h0);

        for (int i = 0; i < 6; i++) begin
            do_start();
            for (int k = 0; k < tbl[i].n; k++) begin
                send(tbl[i].bytes[47 - 8*k -: 8]);
                if (k == 0)
                    chk($sformatf("vec%0d addressed", i), 64'(addressed),
                        64'(tbl[i].bytes[47:41] == 7'h21));
            end
            finish_txn($sformatf("vec%0d", i), tbl[i].regs, tbl[i].upd);
        end

        // repeated start: both segments commit together
        do_start();
        send(8'h42); send(8'h02); send(8'h0A); send(8'h0B);
        do_start();
        chk("rstart addressed dropped", 64'(addressed), 64'h0);
        send(8'h42); send(8'h00); send(8'h0C); send(8'h0D);
        finish_txn("rstart", 64'hAAAA_0A0B_1234_0C0D, 1'b1);

        // reset between two words
        do_start();
        send(8'h42); send(8'h01); send(8'h77); send(8'h77);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midreset regs", regs_out, 64'h0);
        chk("midreset update", 64'(update), 64'h0);
        chk("midreset addressed", 64'(addressed), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        cur = 64'h0;
        send(8'h88); send(8'h99);
        finish_txn("after reset", 64'h0, 1'b0);

        // randomized transactions against a list-of-pending-writes model
        for (int t = 0; t < 40; t++) begin
            pend_val.delete();
            pend_idx.delete();
            last_match = 1'b0;
            for (int s = 0; s < $urandom_range(1, 2); s++) begin
                do_start();
                a = ($urandom_range(0, 3) != 0) ? {7'h21, 1'($urandom)} : 8'($urandom);
                match = a[7:1] == 7'h21;
                send(a);
                chk($sformatf("rnd%0d addressed", t), 64'(addressed), 64'(match));
                if (!match) begin
                    pend_val.delete();
                    pend_idx.delete();
                end
                p = ($urandom_range(0, 4) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
                send(p);
                nb = $urandom_range(0, 9);
                for (int k = 0; k < nb; k++) begin
                    a = 8'($urandom);
                    send(a);
                    if (k % 2 == 0) hi = a;
                    else if (match && p < 4) begin
                        pend_idx.push_back((int'(p) + k / 2) % 4);
                        pend_val.push_back({hi, a});
                    end
                end
                last_match = match;
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            exp = cur;
            if (last_match)
                foreach (pend_idx[j]) exp[16*pend_idx[j] +: 16] = pend_val[j];
            finish_txn($sformatf("rnd%0d", t), exp, last_match && pend_idx.size() > 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
